mult_div_unit: RTL and testbench

Iterative multiply/divide unit for the execute stage, directly downstream of the register file. Consumes the two register-file read operands and computes 32x32 signed/unsigned products and quotient/remainder pairs one bit per cycle. Results land in architectural HI/LO registers, readable by the datapath for MFHI/MFLO and writable for MTHI/MTLO.

---
 rtl/mult_div_unit_pkg.sv | 21 ++
 rtl/mult_div_unit_cond_negate.sv | 12 +
 rtl/mult_div_unit.sv | 168 ++++++++++++++++
 tb/tb_mult_div_unit.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/mult_div_unit_pkg.sv
// Shared encodings and constants for the iterative multiply/divide unit.
package mult_div_unit_pkg;

  localparam int unsigned Width   = 32;
  localparam int unsigned NumIter = 32;

  typedef enum logic [1:0] {
    OpMultu = 2'b00,
    OpMult  = 2'b01,
    OpDivu  = 2'b10,
    OpDiv   = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StRun   = 2'b01,
    StFixup = 2'b10,
    StDone  = 2'b11
  } state_e;

endpackage

// File: rtl/mult_div_unit_cond_negate.sv
// Combinational conditional two's-complement negate.
module mult_div_unit_cond_negate #(
  parameter int unsigned Width = 32
) (
  input  logic [Width-1:0] in_i,
  input  logic             neg_i,
  output logic [Width-1:0] out_o
);

  assign out_o = neg_i ? (~in_i + Width'(1)) : in_i;

endmodule

// File: rtl/mult_div_unit.sv
// Iterative 32x32 multiply / restoring divide, one bit per cycle, results in HI/LO.
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int unsigned WIDTH = Width
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             Start,
  input  logic [1:0]       Op,
  input  logic [WIDTH-1:0] OperandA,
  input  logic [WIDTH-1:0] OperandB,
  input  logic             WriteHi,
  input  logic             WriteLo,
  input  logic [WIDTH-1:0] WriteData,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo,
  output logic             Busy,
  output logic             Done
);

  state_e             state_q, state_d;
  op_e                op_q, op_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   a_orig_q, a_orig_d;
  logic [31:0]        cnt_q, cnt_d;
  logic               quot_neg_q, quot_neg_d;
  logic               rem_neg_q, rem_neg_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic               busy_q, busy_d, done_q, done_d;

  logic [WIDTH-1:0]   mag_a, mag_b, quot_fix, rem_fix;
  logic [2*WIDTH-1:0] prod_fix, mul_next, div_next;
  logic [WIDTH:0]     mul_sum, div_trial;

  mult_div_unit_cond_negate #(.Width(WIDTH)) u_neg_a (
    .in_i  (OperandA),
    .neg_i (Op[0] & OperandA[WIDTH-1]),
    .out_o (mag_a)
  );

  mult_div_unit_cond_negate #(.Width(WIDTH)) u_neg_b (
    .in_i  (OperandB),
    .neg_i (Op[0] & OperandB[WIDTH-1]),
    .out_o (mag_b)
  );

  mult_div_unit_cond_negate #(.Width(2*WIDTH)) u_fix_prod (
    .in_i  (acc_q),
    .neg_i (quot_neg_q),
    .out_o (prod_fix)
  );

  mult_div_unit_cond_negate #(.Width(WIDTH)) u_fix_quot (
    .in_i  (acc_q[WIDTH-1:0]),
    .neg_i (quot_neg_q),
    .out_o (quot_fix)
  );

  mult_div_unit_cond_negate #(.Width(WIDTH)) u_fix_rem (
    .in_i  (acc_q[2*WIDTH-1:WIDTH]),
    .neg_i (rem_neg_q),
    .out_o (rem_fix)
  );

  // Multiply: accumulator is {partial product, remaining multiplier bits}.
  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, b_q};
  assign mul_next = acc_q[0] ? {mul_sum, acc_q[WIDTH-1:1]} : {1'b0, acc_q[2*WIDTH-1:1]};

  // Divide: trial subtract is 33 bits wide so the bit shifted out of rem is not lost.
  assign div_trial = acc_q[2*WIDTH-1:WIDTH-1] - {1'b0, b_q};
  assign div_next  = div_trial[WIDTH] ? {acc_q[2*WIDTH-2:0], 1'b0}
                                      : {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    acc_d      = acc_q;
    b_d        = b_q;
    a_orig_d   = a_orig_q;
    cnt_d      = cnt_q;
    quot_neg_d = quot_neg_q;
    rem_neg_d  = rem_neg_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    busy_d     = busy_q;
    done_d     = 1'b0;

    if (!busy_q) begin
      if (WriteHi) hi_d = WriteData;
      if (WriteLo) lo_d = WriteData;
    end

    unique case (state_q)
      StIdle, StDone: begin
        state_d = StIdle;
        if (Start) begin
          op_d       = op_e'(Op);
          b_d        = Op[1] ? mag_b : mag_a;
          acc_d      = {{WIDTH{1'b0}}, (Op[1] ? mag_a : mag_b)};
          a_orig_d   = OperandA;
          quot_neg_d = Op[0] & (OperandA[WIDTH-1] ^ OperandB[WIDTH-1]);
          rem_neg_d  = Op[0] & OperandA[WIDTH-1];
          cnt_d      = '0;
          busy_d     = 1'b1;
          state_d    = StRun;
        end
      end
      StRun: begin
        acc_d = op_q[1] ? div_next : mul_next;
        cnt_d = cnt_q + 32'd1;
        if (cnt_q == 32'(NumIter - 1)) state_d = StFixup;
      end
      StFixup: begin
        if (!op_q[1]) begin
          {hi_d, lo_d} = prod_fix;
        end else if (op_q == OpDiv && b_q == '0) begin
          lo_d = '1;
          hi_d = a_orig_q;
        end else begin
          lo_d = quot_fix;
          hi_d = rem_fix;
        end
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = StDone;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q    <= StIdle;
      op_q       <= OpMultu;
      acc_q      <= '0;
      b_q        <= '0;
      a_orig_q   <= '0;
      cnt_q      <= '0;
      quot_neg_q <= 1'b0;
      rem_neg_q  <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      acc_q      <= acc_d;
      b_q        <= b_d;
      a_orig_q   <= a_orig_d;
      cnt_q      <= cnt_d;
      quot_neg_q <= quot_neg_d;
      rem_neg_q  <= rem_neg_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign Hi   = hi_q;
  assign Lo   = lo_q;
  assign Busy = busy_q;
  assign Done = done_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed self-checking bench for mult_div_unit.
module tb_mult_div_unit;

  logic        Clk;
  logic        Reset_n;
  logic        Start;
  logic [1:0]  Op;
  logic [31:0] OperandA, OperandB;
  logic        WriteHi, WriteLo;
  logic [31:0] WriteData;
  logic [31:0] Hi, Lo;
  logic        Busy, Done;

  int n_tests;
  int n_fail;

  mult_div_unit #(.WIDTH(32)) dut (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .Start     (Start),
    .Op        (Op),
    .OperandA  (OperandA),
    .OperandB  (OperandB),
    .WriteHi   (WriteHi),
    .WriteLo   (WriteLo),
    .WriteData (WriteData),
    .Hi        (Hi),
    .Lo        (Lo),
    .Busy      (Busy),
    .Done      (Done)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Issues one op; cyc is the index of the cycle (cycle 1 follows the accepting edge) where
  // Done is first seen, or -1. At index inj a second Start plus a WriteLo are driven.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int inj, output int cyc, output int busy_n,
                        output logic done_at_start);
    @(negedge Clk);
    done_at_start = Done;
    Start = 1'b1; Op = op; OperandA = a; OperandB = b;
    @(posedge Clk); #1;
    Start = 1'b0; OperandA = ~a; OperandB = ~b;
    busy_n = 0;
    cyc = -1;
    for (int i = 1; i <= 100; i++) begin
      if (Busy) busy_n++;
      if (Done) begin
        cyc = i;
        break;
      end
      if (i == inj) begin
        Start = 1'b1; Op = 2'b00; OperandA = 32'd2; OperandB = 32'd3;
        WriteLo = 1'b1; WriteData = 32'h0000_AAAA;
      end else if (i == inj + 1) begin
        Start = 1'b0; WriteLo = 1'b0;
      end
      @(posedge Clk); #1;
    end
  endtask

  int   cyc, busy_n;
  logic das;
  logic seen_done;

  initial begin
    n_tests = 0; n_fail = 0;
    Reset_n = 1'b0; Start = 1'b0; Op = 2'b00; OperandA = '0; OperandB = '0;
    WriteHi = 1'b0; WriteLo = 1'b0; WriteData = '0;
    #3;
    check_eq("reset_hi",   64'(Hi),   64'h0);
    check_eq("reset_lo",   64'(Lo),   64'h0);
    check_eq("reset_busy", 64'(Busy), 64'h0);
    check_eq("reset_done", 64'(Done), 64'h0);
    @(negedge Clk); Reset_n = 1'b1;

    // MULTU max x max, with latency and busy-length checks
    run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -10, cyc, busy_n, das);
    check_eq("multu_hi",    64'(Hi), 64'hFFFF_FFFE);
    check_eq("multu_lo",    64'(Lo), 64'h0000_0001);
    check_eq("multu_cycle", 64'(cyc), 64'd34);
    check_eq("multu_busy",  64'(busy_n), 64'd33);
    check_eq("done_busy_low", 64'(Busy), 64'h0);
    @(posedge Clk); #1;
    check_eq("done_one_cycle", 64'(Done), 64'h0);

    run_op(2'b01, 32'hFFFF_FFFD, 32'h0000_0005, -10, cyc, busy_n, das);
    check_eq("mult_hi", 64'(Hi), 64'hFFFF_FFFF);
    check_eq("mult_lo", 64'(Lo), 64'hFFFF_FFF1);

    run_op(2'b11, 32'hFFFF_FFF9, 32'h0000_0002, -10, cyc, busy_n, das);
    check_eq("div_neg_lo",    64'(Lo), 64'hFFFF_FFFD);
    check_eq("div_neg_hi",    64'(Hi), 64'hFFFF_FFFF);
    check_eq("div_neg_cycle", 64'(cyc), 64'd34);

    // DIVU 7/2 with a Start and a WriteLo injected while busy
    run_op(2'b10, 32'd7, 32'd2, 5, cyc, busy_n, das);
    check_eq("divu_lo",    64'(Lo), 64'd3);
    check_eq("divu_hi",    64'(Hi), 64'd1);
    check_eq("divu_cycle", 64'(cyc), 64'd34);
    @(posedge Clk); #1;
    check_eq("busy_start_ignored", 64'(Busy), 64'h0);

    @(negedge Clk); WriteLo = 1'b1; WriteData = 32'h0000_AAAA;
    @(posedge Clk); #1; WriteLo = 1'b0;
    check_eq("writelo_lo", 64'(Lo), 64'h0000_AAAA);
    check_eq("writelo_hi", 64'(Hi), 64'd1);
    @(negedge Clk); WriteHi = 1'b1; WriteData = 32'h0000_0055;
    @(posedge Clk); #1; WriteHi = 1'b0;
    check_eq("writehi_hi", 64'(Hi), 64'h0000_0055);
    check_eq("writehi_lo", 64'(Lo), 64'h0000_AAAA);

    run_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, -10, cyc, busy_n, das);
    check_eq("div_ovf_lo", 64'(Lo), 64'h8000_0000);
    check_eq("div_ovf_hi", 64'(Hi), 64'h0);

    // Issued during the DONE cycle of the previous op
    run_op(2'b10, 32'h0000_1234, 32'h0, -10, cyc, busy_n, das);
    check_eq("b2b_done_at_start", 64'(das), 64'h1);
    check_eq("b2b_cycle",   64'(cyc), 64'd34);
    check_eq("divu_z_lo",   64'(Lo), 64'hFFFF_FFFF);
    check_eq("divu_z_hi",   64'(Hi), 64'h0000_1234);

    run_op(2'b11, 32'hFFFF_FFF0, 32'h0, -10, cyc, busy_n, das);
    check_eq("div_z_lo",    64'(Lo), 64'hFFFF_FFFF);
    check_eq("div_z_hi",    64'(Hi), 64'hFFFF_FFF0);
    check_eq("div_z_cycle", 64'(cyc), 64'd34);

    // Reset in cycle 10 of a DIV
    @(negedge Clk);
    Start = 1'b1; Op = 2'b11; OperandA = 32'd100; OperandB = 32'd7;
    @(posedge Clk); #1; Start = 1'b0;
    repeat (9) @(posedge Clk);
    #2;
    check_eq("mid_busy_before", 64'(Busy), 64'h1);
    Reset_n = 1'b0;
    #1;
    check_eq("mid_rst_busy", 64'(Busy), 64'h0);
    check_eq("mid_rst_hi",   64'(Hi),   64'h0);
    check_eq("mid_rst_lo",   64'(Lo),   64'h0);
    check_eq("mid_rst_done", 64'(Done), 64'h0);
    @(negedge Clk); Reset_n = 1'b1;
    seen_done = 1'b0;
    repeat (40) begin
      @(posedge Clk); #1;
      if (Done) seen_done = 1'b1;
    end
    check_eq("mid_rst_no_done", 64'(seen_done), 64'h0);
    check_eq("mid_rst_idle",    64'(Busy),      64'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
